// File: rtl/seq_multiplier.sv
// Sequential shift-add multiplier: one partial product per clock, valid/ready on both sides.
// Define MULT_SIGNED_EN to add the sgn port and per-operation two's complement multiplication.
module seq_multiplier #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
`ifdef MULT_SIGNED_EN
    input  logic               sgn,
`endif
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] c,
    output logic               busy
);

    localparam int PW = 2 * WIDTH;
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic [PW-1:0]    acc_q, acc_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [PW-1:0]    c_q, c_d;
    logic             outValid_q, outValid_d;

    logic [WIDTH-1:0] opA, opB;
    logic [PW-1:0]    addend, accNext;

`ifdef MULT_SIGNED_EN
    logic neg_q, neg_d, negIn;

    // Magnitudes stay WIDTH-bit unsigned, so the most negative operand maps cleanly.
    assign opA   = (sgn && a[WIDTH-1]) ? -a : a;
    assign opB   = (sgn && b[WIDTH-1]) ? -b : b;
    assign negIn = sgn & (a[WIDTH-1] ^ b[WIDTH-1]);
`else
    assign opA = a;
    assign opB = b;
`endif

    always_comb begin
        state_d  = state_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        c_d      = c_q;
`ifdef MULT_SIGNED_EN
        neg_d    = neg_q;
`endif
        addend   = mplier_q[0] ? (PW'(mcand_q) << cnt_q) : '0;
        accNext  = acc_q + addend;

        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    mcand_d  = opA;
                    mplier_d = opB;
                    acc_d    = '0;
                    cnt_d    = '0;
`ifdef MULT_SIGNED_EN
                    neg_d    = negIn;
`endif
                    state_d  = RUN;
                end
            end
            RUN: begin
                acc_d    = accNext;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + CW'(1);
                if (cnt_q == LAST) begin
                    state_d = DONE;
`ifdef MULT_SIGNED_EN
                    c_d     = neg_q ? -accNext : accNext;
`else
                    c_d     = accNext;
`endif
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        outValid_d = (state_d == DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            mcand_q    <= '0;
            mplier_q   <= '0;
            acc_q      <= '0;
            cnt_q      <= '0;
            c_q        <= '0;
            outValid_q <= 1'b0;
`ifdef MULT_SIGNED_EN
            neg_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            mcand_q    <= mcand_d;
            mplier_q   <= mplier_d;
            acc_q      <= acc_d;
            cnt_q      <= cnt_d;
            c_q        <= c_d;
            outValid_q <= outValid_d;
`ifdef MULT_SIGNED_EN
            neg_q      <= neg_d;
`endif
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign out_valid = outValid_q;
    assign c         = c_q;

endmodule
